// File: rtl/axis_packet_fifo.sv
// axis_packet_fifo: store-and-forward AXI-Stream packet FIFO. A packet is released only once its
// TLAST beat is stored; a packet that cannot fit in the whole buffer is discarded and counted.
module axis_packet_fifo #(
    parameter int C_AXIS_DATA_WIDTH = 32,
    parameter int C_ADDR_WIDTH      = 9,
    parameter int C_DROP_CNT_WIDTH  = 16
) (
    input  logic                         ACLK,
    input  logic                         ARESETN,
    input  logic [C_AXIS_DATA_WIDTH-1:0] S_AXIS_TDATA,
    input  logic                         S_AXIS_TLAST,
    input  logic                         S_AXIS_TVALID,
    output logic                         S_AXIS_TREADY,
    output logic [C_AXIS_DATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic                         M_AXIS_TLAST,
    output logic                         M_AXIS_TVALID,
    input  logic                         M_AXIS_TREADY,
    output logic [C_DROP_CNT_WIDTH-1:0]  DROP_COUNT,
    output logic                         DROP_PULSE
);
    localparam int DW    = C_AXIS_DATA_WIDTH;
    localparam int AW    = C_ADDR_WIDTH;
    localparam int DEPTH = 2 ** AW;

    typedef enum logic [1:0] {IDLE, WRITE, DROP} wstate_t;

    wstate_t     state;
    logic [DW:0] mem [DEPTH];
    logic [AW:0] wr_ptr, commit_ptr, rd_ptr;
    logic        ready_en;
    logic        full, s_accept, readable, rd_en, pop;
    logic [DW:0] rdata, skid;
    logic        rv, sk_valid;
    logic [1:0]  occ;

    assign full          = (wr_ptr - rd_ptr) == {1'b1, {AW{1'b0}}};
    assign S_AXIS_TREADY = ready_en && (state == DROP || !full);
    assign s_accept      = S_AXIS_TVALID && S_AXIS_TREADY;
    assign readable      = rd_ptr != commit_ptr;
    assign pop           = M_AXIS_TVALID && M_AXIS_TREADY;
    // Beats held in the output pair plus the one in flight from the RAM; a new read is issued
    // only if it is guaranteed a slot when it lands a cycle later.
    assign occ           = {1'b0, M_AXIS_TVALID} + {1'b0, sk_valid} + {1'b0, rv};
    assign rd_en         = readable && (occ - {1'b0, pop}) <= 2'd1;

    always_ff @(posedge ACLK) begin
        if (s_accept && state != DROP)
            mem[wr_ptr[AW-1:0]] <= {S_AXIS_TLAST, S_AXIS_TDATA};
        if (rd_en)
            rdata <= mem[rd_ptr[AW-1:0]];
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            commit_ptr <= '0;
            ready_en   <= 1'b0;
            DROP_COUNT <= '0;
            DROP_PULSE <= 1'b0;
        end else begin
            ready_en   <= 1'b1;
            DROP_PULSE <= 1'b0;
            if (state == DROP) begin
                if (s_accept && S_AXIS_TLAST) begin
                    state      <= IDLE;
                    DROP_PULSE <= 1'b1;
                    if (!(&DROP_COUNT))
                        DROP_COUNT <= DROP_COUNT + 1'b1;
                end
            end else if (s_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (S_AXIS_TLAST) begin
                    commit_ptr <= wr_ptr + 1'b1;
                    state      <= IDLE;
                end else begin
                    state <= WRITE;
                end
            end else if (full && commit_ptr == rd_ptr) begin
                // The open packet alone fills the buffer: it can never complete, so discard it.
                state  <= DROP;
                wr_ptr <= commit_ptr;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rd_ptr        <= '0;
            rv            <= 1'b0;
            sk_valid      <= 1'b0;
            skid          <= '0;
            M_AXIS_TVALID <= 1'b0;
            M_AXIS_TLAST  <= 1'b0;
            M_AXIS_TDATA  <= '0;
        end else begin
            rv <= rd_en;
            if (rd_en)
                rd_ptr <= rd_ptr + 1'b1;
            if (!M_AXIS_TVALID || M_AXIS_TREADY) begin
                if (sk_valid) begin
                    {M_AXIS_TLAST, M_AXIS_TDATA} <= skid;
                    M_AXIS_TVALID                <= 1'b1;
                    sk_valid                     <= rv;
                    skid                         <= rdata;
                end else begin
                    M_AXIS_TVALID <= rv;
                    if (rv)
                        {M_AXIS_TLAST, M_AXIS_TDATA} <= rdata;
                end
            end else if (rv) begin
                skid     <= rdata;
                sk_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_axis_packet_fifo.sv
// tb_axis_packet_fifo: directed and randomized traffic against a packet-level scoreboard
// (complete packets up to DEPTH beats pass intact and in order; longer ones are dropped and counted).
module tb_axis_packet_fifo;
    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int CW    = 2;
    localparam int DEPTH = 1 << AW;
    localparam int CMAX  = (1 << CW) - 1;

    logic          ACLK = 1'b0;
    logic          ARESETN = 1'b0;
    logic [DW-1:0] S_AXIS_TDATA = '0;
    logic          S_AXIS_TLAST = 1'b0;
    logic          S_AXIS_TVALID = 1'b0;
    logic          S_AXIS_TREADY;
    logic [DW-1:0] M_AXIS_TDATA;
    logic          M_AXIS_TLAST;
    logic          M_AXIS_TVALID;
    logic          M_AXIS_TREADY = 1'b0;
    logic [CW-1:0] DROP_COUNT;
    logic          DROP_PULSE;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_pulse = 0;
    int          exp_cnt = 0;
    logic        exp_pulse = 1'b0;
    logic        stall = 1'b0;
    logic [DW:0] held;
    logic [DW:0] exp_q[$];
    logic [DW:0] cur[$];
    logic [DW:0] out_log[$];
    logic        rand_rdy = 1'b0;
    logic        m_rdy_set = 1'b0;
    int          exp_dc[5] = '{1, 2, 3, 3, 3};

    axis_packet_fifo #(
        .C_AXIS_DATA_WIDTH(DW),
        .C_ADDR_WIDTH(AW),
        .C_DROP_CNT_WIDTH(CW)
    ) dut (
        .ACLK(ACLK),
        .ARESETN(ARESETN),
        .S_AXIS_TDATA(S_AXIS_TDATA),
        .S_AXIS_TLAST(S_AXIS_TLAST),
        .S_AXIS_TVALID(S_AXIS_TVALID),
        .S_AXIS_TREADY(S_AXIS_TREADY),
        .M_AXIS_TDATA(M_AXIS_TDATA),
        .M_AXIS_TLAST(M_AXIS_TLAST),
        .M_AXIS_TVALID(M_AXIS_TVALID),
        .M_AXIS_TREADY(M_AXIS_TREADY),
        .DROP_COUNT(DROP_COUNT),
        .DROP_PULSE(DROP_PULSE)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic fail(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: bound expired (t=%0t)", nm, $time);
    endtask

    function automatic logic [DW:0] beat(input logic [DW-1:0] d, input logic l);
        return {l, d};
    endfunction

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic l);
        int t = 0;
        S_AXIS_TDATA  = d;
        S_AXIS_TLAST  = l;
        S_AXIS_TVALID = 1'b1;
        @(negedge ACLK);
        while (!S_AXIS_TREADY && t < 2000) begin
            t++;
            @(negedge ACLK);
        end
        if (!S_AXIS_TREADY)
            fail("s_ready_timeout");
        tick();
    endtask

    task automatic send_pkt(input logic [DW-1:0] base, input int len);
        for (int i = 0; i < len; i++)
            send_beat(base + DW'(i), i == len - 1);
        S_AXIS_TVALID = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        @(negedge ACLK);
        while ((exp_q.size() != 0 || M_AXIS_TVALID) && t < 4000) begin
            @(negedge ACLK);
            t++;
        end
        if (t >= 4000)
            fail("drain_timeout");
    endtask

    task automatic do_reset();
        S_AXIS_TVALID = 1'b0;
        S_AXIS_TLAST  = 1'b0;
        tick();
        ARESETN = 1'b0;
        repeat (2) tick();
        ARESETN = 1'b1;
        tick();
    endtask

    initial forever begin
        @(posedge ACLK);
        #1;
        M_AXIS_TREADY = rand_rdy ? 1'($urandom_range(0, 1)) : m_rdy_set;
    end

    // Scoreboard: a packet's beats become expected output once its TLAST is accepted,
    // unless the packet is longer than the buffer, in which case a drop is expected instead.
    always @(negedge ACLK) begin
        if (!ARESETN) begin
            chk("rst_m_valid", M_AXIS_TVALID, 0);
            chk("rst_s_ready", S_AXIS_TREADY, 0);
            chk("rst_drop_count", DROP_COUNT, 0);
            exp_q.delete();
            cur.delete();
            out_log.delete();
            exp_cnt   = 0;
            exp_pulse = 1'b0;
            stall     = 1'b0;
        end else begin
            chk("drop_count", DROP_COUNT, exp_cnt);
            chk("drop_pulse", DROP_PULSE, exp_pulse);
            if (DROP_PULSE)
                n_pulse++;
            chk("no_early_valid", M_AXIS_TVALID && exp_q.size() == 0, 0);
            if (stall)
                chk("hold_stable", {M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TDATA}, {1'b1, held});
            if (M_AXIS_TVALID && M_AXIS_TREADY && exp_q.size() != 0) begin
                chk("out_beat", {M_AXIS_TLAST, M_AXIS_TDATA}, exp_q[0]);
                out_log.push_back({M_AXIS_TLAST, M_AXIS_TDATA});
                void'(exp_q.pop_front());
            end
            stall     = M_AXIS_TVALID && !M_AXIS_TREADY;
            held      = {M_AXIS_TLAST, M_AXIS_TDATA};
            exp_pulse = 1'b0;
            if (S_AXIS_TVALID && S_AXIS_TREADY) begin
                cur.push_back({S_AXIS_TLAST, S_AXIS_TDATA});
                if (S_AXIS_TLAST) begin
                    if (cur.size() > DEPTH) begin
                        exp_pulse = 1'b1;
                        if (exp_cnt < CMAX)
                            exp_cnt++;
                    end else begin
                        foreach (cur[i])
                            exp_q.push_back(cur[i]);
                    end
                    cur.delete();
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        int n_keep;
        int n_over;
        m_rdy_set = 1'b1;
        do_reset();
        tick();

        // 4-beat packet, consumer always ready: exact release latency and beat order
        send_pkt(32'hA0, 4);
        @(negedge ACLK);
        chk("t1_wait1", M_AXIS_TVALID, 0);
        @(negedge ACLK);
        chk("t1_wait2", M_AXIS_TVALID, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge ACLK);
            chk("t1_valid", M_AXIS_TVALID, 1);
            chk("t1_beat", {M_AXIS_TLAST, M_AXIS_TDATA}, beat(32'hA0 + DW'(i), i == 3));
        end
        @(negedge ACLK);
        chk("t1_after", M_AXIS_TVALID, 0);
        tick();

        // Consumer stalled: two 8-beat packets fill the buffer, a third one stalls without a drop
        m_rdy_set = 1'b0;
        tick();
        tick();
        out_log.delete();
        send_pkt(32'h100, 8);
        send_pkt(32'h200, 8);
        fork
            send_pkt(32'h300, 8);
        join_none
        repeat (40) @(posedge ACLK);
        @(negedge ACLK);
        chk("t2_s_ready", S_AXIS_TREADY, 0);
        chk("t2_drops", DROP_COUNT, 0);
        chk("t2_head", {M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TDATA}, {1'b1, beat(32'h100, 0)});
        m_rdy_set = 1'b1;
        wait fork;
        drain();
        chk("t2_count", out_log.size(), 24);
        chk("t2_first", out_log[0], beat(32'h100, 0));
        chk("t2_mid", out_log[15], beat(32'h207, 1));
        chk("t2_last", out_log[23], beat(32'h307, 1));
        tick();

        // Oversize packet is dropped; the following packet passes intact
        out_log.delete();
        send_pkt(32'h500, 20);
        @(negedge ACLK);
        chk("t3_pulse", DROP_PULSE, 1);
        chk("t3_count", DROP_COUNT, 1);
        @(negedge ACLK);
        chk("t3_pulse_end", DROP_PULSE, 0);
        tick();
        send_pkt(32'hB0, 3);
        drain();
        chk("t3_size", out_log.size(), 3);
        chk("t3_b0", out_log[0], beat(32'hB0, 0));
        chk("t3_b2", out_log[2], beat(32'hB2, 1));
        tick();

        // 200 single-beat packets with random source gaps and random consumer ready
        do_reset();
        out_log.delete();
        rand_rdy = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                S_AXIS_TVALID = 1'b0;
                tick();
            end
            send_beat(32'h1000 + DW'(i), 1'b1);
        end
        S_AXIS_TVALID = 1'b0;
        rand_rdy  = 1'b0;
        m_rdy_set = 1'b1;
        drain();
        chk("t4_count", out_log.size(), 200);
        chk("t4_first", out_log[0], beat(32'h1000, 1));
        chk("t4_last", out_log[199], beat(32'h10C7, 1));
        chk("t4_drops", DROP_COUNT, 0);
        tick();

        // Random packet lengths, including oversize ones, with random consumer ready
        out_log.delete();
        n_keep = 0;
        n_over = 0;
        rand_rdy = 1'b1;
        for (int p = 0; p < 40; p++) begin
            len = $urandom_range(1, DEPTH + 4);
            if (len > DEPTH)
                n_over++;
            else
                n_keep += len;
            repeat ($urandom_range(0, 3)) tick();
            send_pkt(32'h2000 + DW'(p * 64), len);
        end
        rand_rdy  = 1'b0;
        m_rdy_set = 1'b1;
        drain();
        chk("t4b_beats", out_log.size(), n_keep);
        chk("t4b_drops", DROP_COUNT, n_over > CMAX ? CMAX : n_over);
        tick();

        // Reset in the middle of a packet with a stored packet waiting at the output
        do_reset();
        m_rdy_set = 1'b0;
        tick();
        send_pkt(32'h600, 2);
        send_beat(32'h700, 1'b0);
        S_AXIS_TVALID = 1'b0;
        repeat (3) tick();
        chk("t5_pre_valid", M_AXIS_TVALID, 1);
        ARESETN = 1'b0;
        #1;
        chk("t5_m_valid", M_AXIS_TVALID, 0);
        chk("t5_s_ready", S_AXIS_TREADY, 0);
        @(posedge ACLK);
        #1;
        ARESETN   = 1'b1;
        m_rdy_set = 1'b1;
        tick();
        send_pkt(32'hC0, 2);
        drain();
        chk("t5_size", out_log.size(), 2);
        chk("t5_c0", out_log[0], beat(32'hC0, 0));
        chk("t5_c1", out_log[1], beat(32'hC1, 1));
        chk("t5_drops", DROP_COUNT, 0);
        tick();

        // Five oversize packets saturate the 2-bit drop counter
        do_reset();
        n_pulse = 0;
        for (int k = 0; k < 5; k++) begin
            send_pkt(32'h800 + DW'(k * 32), DEPTH + 1);
            @(negedge ACLK);
            chk("t6_pulse", DROP_PULSE, 1);
            chk("t6_count", DROP_COUNT, exp_dc[k]);
            tick();
        end
        tick();
        @(negedge ACLK);
        chk("t6_pulses", n_pulse, 5);
        chk("t6_no_out", M_AXIS_TVALID, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
